// File: rtl/fp_round_pkg.sv
// Shared types and constants for the pipelined IEEE-754 rounding/packing unit.
package fp_round_pkg;

  typedef enum logic [2:0] {
    Rne = 3'b000,
    Rtz = 3'b001,
    Rdn = 3'b010,
    Rup = 3'b011,
    Rmm = 3'b100
  } rm_e;

  // Result class picked by the S1 priority chain.
  typedef enum logic [2:0] {
    ClsNan,
    ClsInf,
    ClsZero,
    ClsOvf,
    ClsUnf,
    ClsRound
  } cls_e;

  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  typedef struct packed {
    logic sign;
    logic fixed;  // field already final, S2 skips the increment
    logic inc;
  } s1_entry_t;

  // Field helpers return {exp, man} right-aligned in 64 bits; callers slice.
  function automatic logic [63:0] ones(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] inf(input int unsigned exp_w, input int unsigned man_w);
    return ones(exp_w) << man_w;
  endfunction

  function automatic logic [63:0] max_finite(input int unsigned exp_w, input int unsigned man_w);
    return ((ones(exp_w) - 64'd1) << man_w) | ones(man_w);
  endfunction

  function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
    return inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Mantissa round-up with exponent carry and post-round overflow detection.
module fp_round_incr #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_norm,
  input  logic [MAN_W-1:0] man_norm,
  input  logic             inc,
  output logic [EXP_W-1:0] exp_rnd,
  output logic [MAN_W-1:0] man_rnd,
  output logic             ovf
);

  logic carry;

  always_comb begin
    {carry, man_rnd} = {1'b0, man_norm} + (MAN_W + 1)'(inc);
    exp_rnd          = exp_norm + EXP_W'(carry);
    ovf              = &exp_rnd;
  end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 round/pack unit with valid/ready handshake and flush.
// Define FP_ROUND_FLAGS_EN to produce fflags; otherwise out_flags is tied to zero.
module fp_round_pipe
  import fp_round_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned GRS_W = 24,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_nan,
  input  logic                     in_inf1,
  input  logic                     in_inf2,
  input  logic                     in_sign1,
  input  logic                     in_sign2,
  input  logic                     in_sign_res,
  input  logic                     in_underflow,
  input  logic [EXP_W-1:0]         in_exp_norm,
  input  logic [MAN_W-1:0]         in_man_norm,
  input  logic [GRS_W-1:0]         in_grs,
  input  logic [2:0]               in_rm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [4:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned FieldW = EXP_W + MAN_W;
  localparam logic [63:0] NanW = canon_nan(EXP_W, MAN_W);
  localparam logic [63:0] InfW = inf(EXP_W, MAN_W);
  localparam logic [63:0] MaxW = max_finite(EXP_W, MAN_W);
  localparam logic [FieldW-1:0] NanBits = NanW[FieldW-1:0];
  localparam logic [FieldW-1:0] InfBits = InfW[FieldW-1:0];
  localparam logic [FieldW-1:0] MaxBits = MaxW[FieldW-1:0];

  logic s1_valid_q, s2_valid_q, s1_load, s2_load;
  s1_entry_t s1_d, s1_q;
  logic [FieldW-1:0] field_d, s1_field_q;
  logic [TAG_W-1:0] s1_tag_q, out_tag_q;
  logic [FieldW:0] result_d, out_result_q;
  cls_e cls;
  logic g, r, s, to_max;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = flush || s1_load;

  assign g = in_grs[GRS_W-1];
  assign r = in_grs[GRS_W-2];
  assign s = |in_grs[GRS_W-3:0];

  always_comb begin
    case (in_rm)
      Rtz:     to_max = 1'b1;
      Rdn:     to_max = !in_sign_res;
      Rup:     to_max = in_sign_res;
      default: to_max = 1'b0;
    endcase
  end

  // S1: classification in priority order plus the round-up decision.
  always_comb begin
    cls        = ClsRound;
    s1_d.sign  = in_sign_res;
    s1_d.inc   = 1'b0;
    field_d    = {in_exp_norm, in_man_norm};
    if (in_rm > 3'd4 || in_nan || (in_inf1 && in_inf2 && (in_sign1 != in_sign2))) begin
      cls       = ClsNan;
      s1_d.sign = 1'b0;
      field_d   = NanBits;
    end else if (in_inf1 || in_inf2) begin
      cls       = ClsInf;
      s1_d.sign = in_inf1 ? in_sign1 : in_sign2;
      field_d   = InfBits;
    end else if (in_exp_norm == '0 && in_man_norm == '0) begin
      cls       = ClsZero;
      s1_d.sign = (in_sign1 == in_sign2) ? in_sign_res : (in_rm == Rdn);
      field_d   = '0;
    end else if (&in_exp_norm) begin
      cls       = ClsOvf;
      field_d   = to_max ? MaxBits : InfBits;
    end else if (in_underflow) begin
      cls       = ClsUnf;
      field_d   = '0;
    end else begin
      case (in_rm)
        Rne:     s1_d.inc = g && (r || s || in_man_norm[0]);
        Rdn:     s1_d.inc = in_sign_res && (g || r || s);
        Rup:     s1_d.inc = !in_sign_res && (g || r || s);
        Rmm:     s1_d.inc = g;
        default: s1_d.inc = 1'b0;
      endcase
    end
    s1_d.fixed = (cls != ClsRound);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
    end
    if (s1_load && in_valid) begin
      s1_q       <= s1_d;
      s1_field_q <= field_d;
      s1_tag_q   <= in_tag;
    end
  end

  // S2: apply the increment and pack.
  logic [EXP_W-1:0] exp_rnd;
  logic [MAN_W-1:0] man_rnd;
  logic ovf, ovf_hit;

  fp_round_incr #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_incr (
    .exp_norm (s1_field_q[FieldW-1:MAN_W]),
    .man_norm (s1_field_q[MAN_W-1:0]),
    .inc      (s1_q.inc),
    .exp_rnd  (exp_rnd),
    .man_rnd  (man_rnd),
    .ovf      (ovf)
  );

  assign ovf_hit = !s1_q.fixed && ovf;

  always_comb begin
    if (s1_q.fixed) begin
      result_d = {s1_q.sign, s1_field_q};
    end else if (ovf_hit) begin
      result_d = {s1_q.sign, InfBits};
    end else begin
      result_d = {s1_q.sign, exp_rnd, man_rnd};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (s2_load) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_load && s1_valid_q) begin
        out_result_q <= result_d;
        out_tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

`ifdef FP_ROUND_FLAGS_EN
  logic [4:0] s1_flags_d, s1_flags_q, out_flags_q, ovf_flags;

  always_comb begin
    s1_flags_d = '0;
    unique case (cls)
      ClsNan:   s1_flags_d[FlagNv] = 1'b1;
      ClsOvf:   begin
        s1_flags_d[FlagOf] = 1'b1;
        s1_flags_d[FlagNx] = 1'b1;
      end
      ClsUnf:   begin
        s1_flags_d[FlagUf] = 1'b1;
        s1_flags_d[FlagNx] = 1'b1;
      end
      ClsRound: s1_flags_d[FlagNx] = g || r || s;
      default:  s1_flags_d = '0;
    endcase
  end

  always_comb begin
    ovf_flags         = '0;
    ovf_flags[FlagOf] = ovf_hit;
    ovf_flags[FlagNx] = ovf_hit;
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      s1_flags_q <= s1_flags_d;
    end
    if (reset) begin
      out_flags_q <= '0;
    end else if (s2_load && s1_valid_q) begin
      out_flags_q <= s1_flags_q | ovf_flags;
    end
  end

  assign out_flags = out_flags_q;
`else
  assign out_flags = '0;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed bench for fp_round_pipe: rounding vectors, specials, backpressure, flush and reset.
module tb_fp_round_pipe;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready;
  logic in_nan, in_inf1, in_inf2, in_sign1, in_sign2, in_sign_res, in_underflow;
  logic [7:0]  in_exp_norm;
  logic [22:0] in_man_norm;
  logic [23:0] in_grs;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags, out_tag;

  int n_asserts = 0;
  int n_fail = 0;

  localparam logic [4:0] FNV = 5'h10, FOF = 5'h04, FUF = 5'h02, FNX = 5'h01;

  always #5 clk = ~clk;

  fp_round_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_nan       (in_nan),
    .in_inf1      (in_inf1),
    .in_inf2      (in_inf2),
    .in_sign1     (in_sign1),
    .in_sign2     (in_sign2),
    .in_sign_res  (in_sign_res),
    .in_underflow (in_underflow),
    .in_exp_norm  (in_exp_norm),
    .in_man_norm  (in_man_norm),
    .in_grs       (in_grs),
    .in_rm        (in_rm),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag)
  );

  function automatic logic [4:0] ef(input logic [4:0] f);
`ifdef FP_ROUND_FLAGS_EN
    return f;
`else
    return 5'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ctl = {nan, inf1, inf2, sign1, sign2, underflow}
  task automatic run_vec(input string name, input logic [2:0] rm, input logic [5:0] ctl,
                         input logic sres, input logic [7:0] e, input logic [22:0] m,
                         input logic [23:0] grs, input logic [31:0] res, input logic [4:0] fl,
                         input logic [4:0] tag);
    {in_nan, in_inf1, in_inf2, in_sign1, in_sign2, in_underflow} = ctl;
    in_rm = rm;
    in_sign_res = sres;
    in_exp_norm = e;
    in_man_norm = m;
    in_grs = grs;
    in_tag = tag;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    check({name, "_lat1"}, 32'(out_valid), 32'd0);
    tick;
    check({name, "_lat2"}, 32'(out_valid), 32'd1);
    check({name, "_res"}, out_result, res);
    check({name, "_flags"}, 32'(out_flags), 32'(ef(fl)));
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    tick;
  endtask

  initial begin
    int sent, rcvd;
    logic stalled;
    logic [31:0] held_res;
    logic [4:0] held_tag;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    {in_nan, in_inf1, in_inf2, in_sign1, in_sign2, in_sign_res, in_underflow} = '0;
    in_exp_norm = '0; in_man_norm = '0; in_grs = '0; in_rm = '0; in_tag = '0;
    tick;
    tick;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", 32'(out_flags), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick;

    run_vec("rne_tie",     3'd0, 6'b000000, 1'b0, 8'h7F, 23'h000001, 24'h800000, 32'h3F800002, FNX, 5'd1);
    run_vec("rne_even",    3'd0, 6'b000000, 1'b0, 8'h7F, 23'h000002, 24'h800000, 32'h3F800002, FNX, 5'd2);
    run_vec("rne_carry",   3'd0, 6'b000000, 1'b0, 8'h7F, 23'h7FFFFF, 24'hC00000, 32'h40000000, FNX, 5'd3);
    run_vec("rne_ovf",     3'd0, 6'b000000, 1'b0, 8'hFE, 23'h7FFFFF, 24'hC00000, 32'h7F800000, FOF | FNX, 5'd4);
    run_vec("ovf_rtz",     3'd1, 6'b000000, 1'b1, 8'hFF, 23'h000000, 24'h000000, 32'hFF7FFFFF, FOF | FNX, 5'd5);
    run_vec("ovf_rdn",     3'd2, 6'b000000, 1'b1, 8'hFF, 23'h000000, 24'h000000, 32'hFF800000, FOF | FNX, 5'd6);
    run_vec("ovf_rup",     3'd3, 6'b000000, 1'b1, 8'hFF, 23'h000000, 24'h000000, 32'hFF7FFFFF, FOF | FNX, 5'd7);
    run_vec("ovf_rne_pos", 3'd0, 6'b000000, 1'b0, 8'hFF, 23'h000000, 24'h000000, 32'h7F800000, FOF | FNX, 5'd8);
    run_vec("inf_inf",     3'd0, 6'b011010, 1'b0, 8'h00, 23'h000000, 24'h000000, 32'h7FC00000, FNV, 5'd9);
    run_vec("inf2_neg",    3'd0, 6'b001010, 1'b0, 8'h00, 23'h000000, 24'h000000, 32'hFF800000, 5'h0, 5'd10);
    run_vec("zero_rdn",    3'd2, 6'b000010, 1'b0, 8'h00, 23'h000000, 24'h000000, 32'h80000000, 5'h0, 5'd11);
    run_vec("zero_rne",    3'd0, 6'b000010, 1'b1, 8'h00, 23'h000000, 24'h000000, 32'h00000000, 5'h0, 5'd12);
    run_vec("rm_bad",      3'd5, 6'b000000, 1'b0, 8'h7F, 23'h000001, 24'h000000, 32'h7FC00000, FNV, 5'd13);
    run_vec("nan",         3'd0, 6'b100000, 1'b1, 8'h7F, 23'h000001, 24'h000000, 32'h7FC00000, FNV, 5'd14);
    run_vec("rtz_trunc",   3'd1, 6'b000000, 1'b0, 8'h7F, 23'h000001, 24'hFFFFFF, 32'h3F800001, FNX, 5'd15);
    run_vec("rdn_neg",     3'd2, 6'b000000, 1'b1, 8'h7F, 23'h000001, 24'h400000, 32'hBF800002, FNX, 5'd16);
    run_vec("rmm_tie",     3'd4, 6'b000000, 1'b0, 8'h7F, 23'h000000, 24'h800000, 32'h3F800001, FNX, 5'd17);
    run_vec("underflow",   3'd0, 6'b000001, 1'b1, 8'h10, 23'h000005, 24'h000000, 32'h80000000, FUF | FNX, 5'd18);

    // Backpressure: four entries, consumer stalled for the first five cycles.
    sent = 0; rcvd = 0; stalled = 1'b0; held_res = '0; held_tag = '0;
    {in_nan, in_inf1, in_inf2, in_sign1, in_sign2, in_sign_res, in_underflow} = '0;
    in_rm = 3'd0; in_exp_norm = 8'h7F; in_grs = '0;
    for (int c = 0; c < 20 && rcvd < 4; c++) begin
      out_ready = (c >= 5);
      in_valid = (sent < 4);
      in_tag = 5'(sent + 1);
      in_man_norm = 23'(sent + 1);
      #1;
      if (c == 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (stalled) begin
        check("bp_stable_res", out_result, held_res);
        check("bp_stable_tag", 32'(out_tag), 32'(held_tag));
      end
      if (out_valid && out_ready) begin
        rcvd++;
        check("bp_order", 32'(out_tag), 32'(rcvd));
        check("bp_data", out_result, 32'h3F800000 | 32'(rcvd));
      end
      stalled = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(rcvd), 32'd4);
    check("bp_no_dup", 32'(out_valid), 32'd0);
    tick;

    // Flush with two entries held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd20; tick;
    in_tag = 5'd21; tick;
    #1;
    check("fl_full_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; in_tag = 5'd22;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid1", 32'(out_valid), 32'd0);
    tick;
    check("fl_valid2", 32'(out_valid), 32'd0);

    // Same again with reset.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 5'd23; in_man_norm = 23'h1; tick;
    in_tag = 5'd24; tick;
    reset = 1'b1; in_tag = 5'd25;
    tick;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rs_valid1", 32'(out_valid), 32'd0);
    check("rs_result", out_result, 32'd0);
    check("rs_flags", 32'(out_flags), 32'd0);
    check("rs_tag", 32'(out_tag), 32'd0);
    tick;
    check("rs_valid2", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
